// File: rtl/spi_cfg_pkg.sv
// Shared definitions for spi_cfg_master: FSM state encoding, frame layout and
// the register map of the SPI configuration peripheral.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIGH,
    S_SLOW,
    S_GAP
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam logic WRITE_BIT = 1'b1;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  localparam logic [6:0] MAX_ADDR         = 7'h04;

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [6:0] addr,
                                                       input logic [7:0] data);
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_cfg_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, pointer flips away from the
// requester just served whenever update is asserted.
module spi_cfg_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       update,
  output logic [1:0] grant
);

  // ptr == 0 favours requester 0 when both are valid
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || !ptr)) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI mode-0 write engine for the configuration peripheral, fed by two
// round-robin arbitrated requesters. Optional SPI_CFG_ADDR_CHECK_EN drops out-of-map writes and pulses err.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid_0,
  input  logic [6:0] req_addr_0,
  input  logic [7:0] req_data_0,
  input  logic       req_valid_1,
  input  logic [6:0] req_addr_1,
  input  logic [7:0] req_data_1,
  output logic       req_ready_0,
  output logic       req_ready_1,
  output logic       nCS,
  output logic       SCLK,
  output logic       COPI,
  output logic       busy,
`ifdef SPI_CFG_ADDR_CHECK_EN
  output logic       err,
`endif
  output logic       done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);
  localparam logic [7:0] GAP_DONE = 8'(GAP - 2);
  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS);

  state_t                state;
  logic [7:0]            half_cnt;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] frame_next;
  logic [1:0]            grant;
  logic                  accept;
  logic                  addr_bad;
  logic                  half_end;
  logic [6:0]            sel_addr;
  logic [7:0]            sel_data;

  spi_cfg_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req_valid_1, req_valid_0}),
    .update (accept),
    .grant  (grant)
  );

  // Grants only reach the requesters while the engine is idle
  assign req_ready_0 = (state == S_IDLE) && grant[0];
  assign req_ready_1 = (state == S_IDLE) && grant[1];
  assign accept      = req_ready_0 || req_ready_1;
  assign sel_addr    = grant[1] ? req_addr_1 : req_addr_0;
  assign sel_data    = grant[1] ? req_data_1 : req_data_0;
  assign frame_next  = make_frame(sel_addr, sel_data);
  assign half_end    = (half_cnt == DIV_LAST);

`ifdef SPI_CFG_ADDR_CHECK_EN
  assign addr_bad = (sel_addr > MAX_ADDR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= accept && addr_bad;
    end
  end
`else
  assign addr_bad = 1'b0;
`endif

  // shreg holds the bits still to be sent; COPI always shows the current bit,
  // and the zero fill makes COPI drop to 0 for the nCS hold period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      half_cnt <= 8'd0;
      bit_cnt  <= 5'd0;
      shreg    <= '0;
      nCS      <= 1'b1;
      SCLK     <= 1'b0;
      COPI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      half_cnt <= half_cnt + 8'd1;
      case (state)
        S_IDLE: begin
          half_cnt <= 8'd0;
          if (accept && !addr_bad) begin
            shreg   <= {frame_next[FRAME_BITS-2:0], 1'b0};
            COPI    <= frame_next[FRAME_BITS-1];
            bit_cnt <= 5'd0;
            nCS     <= 1'b0;
            busy    <= 1'b1;
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (half_end) begin
            half_cnt <= 8'd0;
            SCLK     <= 1'b1;
            state    <= S_SHIGH;
          end
        end
        S_SHIGH: begin
          if (half_end) begin
            half_cnt <= 8'd0;
            SCLK     <= 1'b0;
            COPI     <= shreg[FRAME_BITS-1];
            shreg    <= {shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt  <= bit_cnt + 5'd1;
            state    <= S_SLOW;
          end
        end
        S_SLOW: begin
          if (half_end) begin
            half_cnt <= 8'd0;
            if (bit_cnt == LAST_BIT) begin
              nCS   <= 1'b1;
              state <= S_GAP;
            end else begin
              SCLK  <= 1'b1;
              state <= S_SHIGH;
            end
          end
        end
        S_GAP: begin
          if (half_cnt == GAP_DONE) begin
            done <= 1'b1;
          end
          if (half_cnt == GAP_LAST) begin
            half_cnt <= 8'd0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
